pipe_hazard_ctrl: RTL and testbench

// - Pipeline sequencing controller for the 5-stage MIPS core (IF/ID/EX/MEM/WB).
// - Generates stall, flush and freeze controls for the PC and the IFID, IDEX, EXMEM and MEMWB registers.
// - Covers three hazard classes:
//   - load-use RAW hazards, which the forwarding unit cannot resolve;
//   - taken branches resolved in MEM;
//   - multi-cycle data-memory accesses, via a req/ready handshake.
// - Sits beside the forwarding unit; consumes pipeline-register fields and drives their write enables.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 25 ++
 rtl/pipe_hazard_ctrl_if.sv | 62 ++++++
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 19 +
 rtl/pipe_hazard_ctrl.sv | 117 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERROR   = 2'd2
  } hz_state_e;

  localparam int REG_ZERO        = 0;
  localparam int MEM_TIMEOUT_DEF = 15;

  // Pipeline-register control bundle driven by the controller.
  typedef struct packed {
    logic pcWrite;
    logic ifidWrite;
    logic idexWrite;
    logic exmemWrite;
    logic ifidFlush;
    logic idexFlush;
    logic exmemFlush;
    logic memwbBubble;
  } hz_ctl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: pipeline fields in, stall/flush controls out.
// HAZARD_PERF_EN adds the stall/flush performance counters.
interface pipe_hazard_ctrl_if #(parameter int REG_AW = 5);

  logic              idex_mem_read;
  logic [REG_AW-1:0] idex_rt;
  logic [REG_AW-1:0] ifid_rs;
  logic [REG_AW-1:0] ifid_rt;
  logic              ifid_uses_rt;
  logic              br_taken;
  logic              mem_req;
  logic              mem_ready;

  logic              pc_write;
  logic              ifid_write;
  logic              idex_write;
  logic              exmem_write;
  logic              ifid_flush;
  logic              idex_flush;
  logic              exmem_flush;
  logic              memwb_bubble;
  logic              err;
  logic [1:0]        state;

`ifdef HAZARD_PERF_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       flush_cnt;

  modport master (
    output idex_mem_read, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt,
           br_taken, mem_req, mem_ready,
    input  pc_write, ifid_write, idex_write, exmem_write,
           ifid_flush, idex_flush, exmem_flush, memwb_bubble,
           err, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  idex_mem_read, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt,
           br_taken, mem_req, mem_ready,
    output pc_write, ifid_write, idex_write, exmem_write,
           ifid_flush, idex_flush, exmem_flush, memwb_bubble,
           err, state, stall_cnt, flush_cnt
  );
`else
  modport master (
    output idex_mem_read, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt,
           br_taken, mem_req, mem_ready,
    input  pc_write, ifid_write, idex_write, exmem_write,
           ifid_flush, idex_flush, exmem_flush, memwb_bubble,
           err, state
  );

  modport slave (
    input  idex_mem_read, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt,
           br_taken, mem_req, mem_ready,
    output pc_write, ifid_write, idex_write, exmem_write,
           ifid_flush, idex_flush, exmem_flush, memwb_bubble,
           err, state
  );
`endif

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use RAW detector: EX-stage load destination vs ID-stage sources.
module load_use_detect
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              memRead,
  input  logic [REG_AW-1:0] exRt,
  input  logic [REG_AW-1:0] idRs,
  input  logic [REG_AW-1:0] idRt,
  input  logic              idUsesRt,
  output logic              hazard
);

  // $0 is hardwired, so a load targeting it never creates a dependency.
  assign hazard = memRead && (exRt != REG_AW'(REG_ZERO)) &&
                  ((exRt == idRs) || (idUsesRt && (exRt == idRt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/freeze sequencing for the 5-stage pipeline.
// HAZARD_PERF_EN adds saturating stall_cnt/flush_cnt outputs.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave hz
);

  localparam logic [3:0] TIMEOUT = 4'(MEM_TIMEOUT);

  hz_state_e  stReg;
  logic [3:0] waitCnt;
  logic       loadUse;
  logic       isErr;
  logic       freeze;
  hz_ctl_t    ctl;

  load_use_detect #(.REG_AW(REG_AW)) u_lud (
    .memRead  (hz.idex_mem_read),
    .exRt     (hz.idex_rt),
    .idRs     (hz.ifid_rs),
    .idRt     (hz.ifid_rt),
    .idUsesRt (hz.ifid_uses_rt),
    .hazard   (loadUse)
  );

  // Encoding 3 is unreachable but decodes as ERROR.
  assign isErr  = (stReg != RUN) && (stReg != MEMWAIT);
  assign freeze = ((stReg == RUN) && hz.mem_req && !hz.mem_ready) ||
                  ((stReg == MEMWAIT) && !hz.mem_ready);

  always_comb begin
    ctl = '0;
    if (!rst) begin
      ctl = '0;
    end else if (isErr || freeze) begin
      ctl.memwbBubble = 1'b1;
    end else begin
      ctl.pcWrite    = 1'b1;
      ctl.ifidWrite  = 1'b1;
      ctl.idexWrite  = 1'b1;
      ctl.exmemWrite = 1'b1;
      // A taken branch squashes the younger load-use victim anyway.
      if (hz.br_taken) begin
        ctl.ifidFlush  = 1'b1;
        ctl.idexFlush  = 1'b1;
        ctl.exmemFlush = 1'b1;
      end else if (loadUse) begin
        ctl.pcWrite   = 1'b0;
        ctl.ifidWrite = 1'b0;
        ctl.idexFlush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stReg   <= RUN;
      waitCnt <= '0;
    end else begin
      unique case (stReg)
        RUN: begin
          if (hz.mem_req && !hz.mem_ready) begin
            stReg   <= MEMWAIT;
            waitCnt <= 4'd1;
          end
        end
        MEMWAIT: begin
          if (hz.mem_ready) begin
            stReg   <= RUN;
            waitCnt <= '0;
          end else if (waitCnt == TIMEOUT) begin
            stReg <= ERROR;
          end else begin
            waitCnt <= waitCnt + 4'd1;
          end
        end
        default: stReg <= ERROR;
      endcase
    end
  end

  assign hz.pc_write     = ctl.pcWrite;
  assign hz.ifid_write   = ctl.ifidWrite;
  assign hz.idex_write   = ctl.idexWrite;
  assign hz.exmem_write  = ctl.exmemWrite;
  assign hz.ifid_flush   = ctl.ifidFlush;
  assign hz.idex_flush   = ctl.idexFlush;
  assign hz.exmem_flush  = ctl.exmemFlush;
  assign hz.memwb_bubble = ctl.memwbBubble;
  assign hz.err          = rst && isErr;
  assign hz.state        = stReg;

`ifdef HAZARD_PERF_EN
  logic [31:0] stallCnt;
  logic [31:0] flushCnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (!isErr && !ctl.pcWrite && (stallCnt != '1)) stallCnt <= stallCnt + 32'd1;
      if (ctl.ifidFlush && (flushCnt != '1))          flushCnt <= flushCnt + 32'd1;
    end
  end

  assign hz.stall_cnt = stallCnt;
  assign hz.flush_cnt = flushCnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table plus multi-cycle sequences.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_AW(5)) hz ();

  pipe_hazard_ctrl #(.REG_AW(5), .MEM_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  int nChecks = 0;
  int nErrors = 0;

  // Expected control byte: {pc,ifid,idex,exmem writes, ifid,idex,exmem flush, memwb bubble}
  localparam logic [7:0] C_RUN   = 8'hF0;
  localparam logic [7:0] C_STALL = 8'h34;
  localparam logic [7:0] C_BR    = 8'hFE;
  localparam logic [7:0] C_FRZ   = 8'h01;
  localparam logic [7:0] C_RST   = 8'h00;

  typedef struct {
    string      name;
    logic       mr;
    logic [4:0] ert, rs, rt;
    logic       ur, br, mq, rdy;
    logic [7:0] expCtl;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [7:0] ctlNow();
    return {hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write,
            hz.ifid_flush, hz.idex_flush, hz.exmem_flush, hz.memwb_bubble};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input logic ur, input logic br,
                       input logic mq, input logic rdy);
    hz.idex_mem_read = mr;
    hz.idex_rt       = ert;
    hz.ifid_rs       = rs;
    hz.ifid_rt       = rt;
    hz.ifid_uses_rt  = ur;
    hz.br_taken      = br;
    hz.mem_req       = mq;
    hz.mem_ready     = rdy;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{"idle",          1'b0, 5'd2, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, C_RUN};
    vecs[1] = '{"lu_rs",         1'b1, 5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, C_STALL};
    vecs[2] = '{"lu_rt",         1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, C_STALL};
    vecs[3] = '{"rt_unused",     1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, C_RUN};
    vecs[4] = '{"load_r0",       1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, C_RUN};
    vecs[5] = '{"no_load",       1'b0, 5'd2, 5'd2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, C_RUN};
    vecs[6] = '{"br_beats_lu",   1'b1, 5'd2, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, C_BR};
    vecs[7] = '{"mem_1cyc",      1'b0, 5'd2, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, C_RUN};
    vecs[8] = '{"mem_1cyc_lu",   1'b1, 5'd7, 5'd7, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, C_STALL};
    vecs[9] = '{"br_only",       1'b0, 5'd2, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, C_BR};

    idle();
    #12;
    chk("rst_ctl",   32'(ctlNow()), 32'(C_RST));
    chk("rst_state", 32'(hz.state), 32'd0);
    chk("rst_err",   32'(hz.err),   32'd0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].mr, vecs[i].ert, vecs[i].rs, vecs[i].rt,
            vecs[i].ur, vecs[i].br, vecs[i].mq, vecs[i].rdy);
      @(negedge clk);
      chk({vecs[i].name, "_ctl"},   32'(ctlNow()), 32'(vecs[i].expCtl));
      chk({vecs[i].name, "_state"}, 32'(hz.state), 32'd0);
      step();
    end

    // Load-use: one stall cycle, then the bubble sits in EX and everything advances.
    drive(1'b1, 5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("seq_lu_stall", 32'(ctlNow()), 32'(C_STALL));
    step();
    drive(1'b0, 5'd0, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("seq_lu_resume", 32'(ctlNow()), 32'(C_RUN));
    step();

    // Memory wait with a branch arriving while frozen.
    drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("mw_first_ctl",   32'(ctlNow()), 32'(C_FRZ));
    chk("mw_first_state", 32'(hz.state), 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      if (i == 1) hz.br_taken = 1'b1;
      @(negedge clk);
      chk("mw_hold_ctl",   32'(ctlNow()), 32'(C_FRZ));
      chk("mw_hold_state", 32'(hz.state), 32'd1);
      step();
    end
    hz.mem_ready = 1'b1;
    @(negedge clk);
    chk("mw_release_ctl",   32'(ctlNow()), 32'(C_BR));
    chk("mw_release_state", 32'(hz.state), 32'd1);
    step();
    idle();
    @(negedge clk);
    chk("mw_after_ctl",   32'(ctlNow()), 32'(C_RUN));
    chk("mw_after_state", 32'(hz.state), 32'd0);
    step();

    // Timeout: 15 edges still waiting, the 16th lands in ERROR.
    drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step();
    chk("to_edge15_state", 32'(hz.state), 32'd1);
    chk("to_edge15_err",   32'(hz.err),   32'd0);
    step();
    chk("to_err_state", 32'(hz.state), 32'd2);
    chk("to_err_flag",  32'(hz.err),   32'd1);
    chk("to_err_ctl",   32'(ctlNow()), 32'(C_FRZ));
    idle();
    step();
    step();
    chk("to_sticky_state", 32'(hz.state), 32'd2);
    chk("to_sticky_err",   32'(hz.err),   32'd1);
    rst = 1'b0;
    #1;
    chk("to_rst_state", 32'(hz.state), 32'd0);
    chk("to_rst_err",   32'(hz.err),   32'd0);
    #2;
    rst = 1'b1;
    @(negedge clk);
    chk("to_post_ctl", 32'(ctlNow()), 32'(C_RUN));
    step();

    // Reset mid-stall with a deferred branch pending.
    drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    chk("ms_wait_state", 32'(hz.state), 32'd1);
    rst = 1'b0;
    #1;
    chk("ms_rst_state", 32'(hz.state), 32'd0);
    chk("ms_rst_ctl",   32'(ctlNow()), 32'(C_RST));
    idle();
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("ms_post_ctl",   32'(ctlNow()), 32'(C_RUN));
    chk("ms_post_state", 32'(hz.state), 32'd0);
    step();

`ifdef HAZARD_PERF_EN
    rst = 1'b0;
    #1;
    chk("perf_rst_stall", hz.stall_cnt, 32'd0);
    chk("perf_rst_flush", hz.flush_cnt, 32'd0);
    rst = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
      step();
      idle();
      step();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);
      step();
      idle();
      step();
    end
    chk("perf_stall_cnt", hz.stall_cnt, 32'd3);
    chk("perf_flush_cnt", hz.flush_cnt, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
